full_add: RTL and testbench

//   Parameterisable ripple-carry full adder: {c_out,sum} = a + b + c_in.

---
 rtl/full_add.sv | 50 +++++
 tb/tb_full_add.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/full_add.sv
// Parameterisable ripple-carry full adder with a combinational result and an
// enable-gated registered copy ({c_out,sum} = a + b + c_in).
module full_add #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             en,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic [WIDTH-1:0] sum_q,
   output logic             c_out_q,
   output logic             ovf_q
);

   logic carry;
   logic carry_msb;

   // One full-adder cell per bit, chained inside a single combinational
   // process so the ripple carry is one scalar rather than a self-feeding vector.
   always_comb begin
      sum       = '0;
      carry     = c_in;
      carry_msb = c_in;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         carry_msb = carry;
         sum[i]    = a[i] ^ b[i] ^ carry;
         carry     = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      c_out = carry;
      ovf   = carry ^ carry_msb;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (en) begin
         sum_q   <= sum;
         c_out_q <= c_out;
         ovf_q   <= ovf;
      end
   end

endmodule

// File: tb/tb_full_add.sv
// Directed self-checking bench for full_add at WIDTH 1, 4 and 8.
module tb_full_add;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;

   logic       a1, b1, c1;
   logic       sum1, co1, ovf1, sum1_q, co1_q, ovf1_q;

   logic [3:0] a4, b4, sum4, sum4_q;
   logic       c4, co4, ovf4, co4_q, ovf4_q;

   logic [7:0] a8, b8, sum8, sum8_q;
   logic       c8, co8, ovf8, co8_q, ovf8_q;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   full_add #(.WIDTH(1)) u1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c_in(c1), .en(en),
      .sum(sum1), .c_out(co1), .ovf(ovf1),
      .sum_q(sum1_q), .c_out_q(co1_q), .ovf_q(ovf1_q)
   );

   full_add #(.WIDTH(4)) u4 (
      .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c_in(c4), .en(en),
      .sum(sum4), .c_out(co4), .ovf(ovf4),
      .sum_q(sum4_q), .c_out_q(co4_q), .ovf_q(ovf4_q)
   );

   full_add #(.WIDTH(8)) u8 (
      .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c_in(c8), .en(en),
      .sum(sum8), .c_out(co8), .ovf(ovf8),
      .sum_q(sum8_q), .c_out_q(co8_q), .ovf_q(ovf8_q)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [7:0] tbl_sum, tbl_co, tbl_ovf;
   logic [2:0] idx;
   logic [8:0] exp9;
   logic       exp_ovf;

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
      a4 = '0;   b4 = '0;   c4 = 1'b0;
      a8 = '0;   b8 = '0;   c8 = 1'b0;
      #1;
      check("rst_sum1_q", sum1_q, 0);
      check("rst_co1_q",  co1_q,  0);
      check("rst_ovf1_q", ovf1_q, 0);
      check("rst_sum4_q", sum4_q, 0);

      // WIDTH=1 truth table, index = {a,b,c_in}
      tbl_sum = 8'b1001_0110;
      tbl_co  = 8'b1110_1000;
      tbl_ovf = 8'b0100_0010;
      for (int i = 0; i < 8; i++) begin
         idx = 3'(i);
         a1 = idx[2]; b1 = idx[1]; c1 = idx[0];
         #10;
         check($sformatf("w1_sum_%0d", i), sum1, tbl_sum[idx]);
         check($sformatf("w1_co_%0d",  i), co1,  tbl_co[idx]);
         check($sformatf("w1_ovf_%0d", i), ovf1, tbl_ovf[idx]);
      end
      check("w1_sum_q_held_in_reset", sum1_q, 0);
      check("w1_co_q_held_in_reset",  co1_q,  0);

      // WIDTH=4 wrap and overflow
      a4 = 4'hF; b4 = 4'h1; c4 = 1'b0; #10;
      check("w4_wrap_sum", sum4, 4'h0);
      check("w4_wrap_co",  co4,  1);
      check("w4_wrap_ovf", ovf4, 0);
      a4 = 4'h7; b4 = 4'h1; c4 = 1'b0; #10;
      check("w4_pos_ovf_sum", sum4, 4'h8);
      check("w4_pos_ovf_co",  co4,  0);
      check("w4_pos_ovf_ovf", ovf4, 1);
      a4 = 4'h8; b4 = 4'h8; c4 = 1'b1; #10;
      check("w4_neg_ovf_sum", sum4, 4'h1);
      check("w4_neg_ovf_co",  co4,  1);
      check("w4_neg_ovf_ovf", ovf4, 1);

      // Latency: release reset between edges, first en=1 edge loads
      @(negedge clk);
      rst_n = 1'b1; en = 1'b1;
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
      #1;
      check("lat_co1_q_before",  co1_q,  0);
      check("lat_ovf1_q_before", ovf1_q, 0);
      check("lat_sum4_q_before", sum4_q, 0);
      @(posedge clk); #1;
      check("lat_sum1_q", sum1_q, 0);
      check("lat_co1_q",  co1_q,  1);
      check("lat_ovf1_q", ovf1_q, 1);
      check("lat_sum4_q", sum4_q, 4'h1);
      check("lat_co4_q",  co4_q,  1);
      check("lat_ovf4_q", ovf4_q, 1);

      // Hold with en=0 while inputs change
      @(negedge clk);
      en = 1'b0;
      a1 = 1'b0; b1 = 1'b0; c1 = 1'b1;
      a4 = 4'h3; b4 = 4'h4; c4 = 1'b0;
      @(posedge clk); #1;
      check("hold_sum1", sum1, 1);
      check("hold_co1",  co1,  0);
      check("hold_sum1_q", sum1_q, 0);
      check("hold_co1_q",  co1_q,  1);
      check("hold_ovf1_q", ovf1_q, 1);
      check("hold_sum4_q", sum4_q, 4'h1);
      @(posedge clk); #1;
      check("hold2_co4_q", co4_q, 1);
      @(negedge clk);
      en = 1'b1;
      @(posedge clk); #1;
      check("reload_sum1_q", sum1_q, 1);
      check("reload_co1_q",  co1_q,  0);
      check("reload_ovf1_q", ovf1_q, 1);
      check("reload_sum4_q", sum4_q, 4'h7);
      check("reload_ovf4_q", ovf4_q, 0);

      // Asynchronous reset between edges
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("arst_sum1_q", sum1_q, 0);
      check("arst_ovf1_q", ovf1_q, 0);
      check("arst_sum4_q", sum4_q, 0);
      check("arst_sum1_comb", sum1, 1);
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      #1;
      check("arst_sum1_track", sum1, 1);
      check("arst_co1_track",  co1,  1);
      @(posedge clk); #1;
      check("arst_edge_co1_q",  co1_q,  0);
      check("arst_edge_sum4_q", sum4_q, 0);
      @(negedge clk);
      rst_n = 1'b1; en = 1'b0;
      @(posedge clk); #1;
      check("post_rst_noen_co1_q", co1_q, 0);
      @(negedge clk);
      en = 1'b1;
      @(posedge clk); #1;
      check("post_rst_sum1_q", sum1_q, 1);
      check("post_rst_co1_q",  co1_q,  1);
      check("post_rst_ovf1_q", ovf1_q, 0);
      check("post_rst_sum4_q", sum4_q, 4'h7);

      // WIDTH=8 random vectors against integer addition
      for (int i = 0; i < 1000; i++) begin
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         c8 = 1'($urandom);
         #1;
         exp9    = {1'b0, a8} + {1'b0, b8} + {8'b0, c8};
         exp_ovf = (a8[7] == b8[7]) && (exp9[7] != a8[7]);
         check($sformatf("w8_rand_%0d_sum", i), {co8, sum8}, exp9);
         check($sformatf("w8_rand_%0d_ovf", i), ovf8, exp_ovf);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
